tile_load_store_ctrl: RTL and testbench

TILE_LOAD_STORE_CTRL -- requirements
Module: tile_load_store_ctrl

---
 rtl/tile_load_store_ctrl.sv | 143 ++++++++++++++
 tb/tb_tile_load_store_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_load_store_ctrl.sv
// Tile sequencer: splits a job into tiles and drives load -> compute -> store per tile.
// state    | meaning
// IDLE     | waiting for cfg_start; one settle cycle after accept (pend_q)
// LD_ISSUE | load_data_start pulse
// LD_WAIT  | waiting for load_data_done
// CP_ISSUE | compute_start pulse
// CP_WAIT  | waiting for compute_done
// ST_ISSUE | store_data_start pulse
// ST_WAIT  | waiting for store_data_done
// NEXT     | advance addresses/remaining/tile_cnt
// FIN      | done (and err) pulse
module tile_load_store_ctrl #(
  parameter int AW  = 12,
  parameter int XAW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic [XAW-1:0] cfg_src_base,
  input  logic [XAW-1:0] cfg_dst_base,
  input  logic [XAW-1:0] cfg_total_len,
  input  logic [AW-1:0]  cfg_tile_len,
  output logic [XAW-1:0] param_raddr,
  output logic [XAW-1:0] param_waddr,
  output logic [AW-1:0]  param_iolen,
  output logic           load_data_start,
  input  logic           load_data_done,
  output logic           compute_start,
  input  logic           compute_done,
  output logic           store_data_start,
  input  logic           store_data_done,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [XAW-1:0] tile_cnt
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LD_ISSUE = 4'd1;
  localparam logic [3:0] S_LD_WAIT  = 4'd2;
  localparam logic [3:0] S_CP_ISSUE = 4'd3;
  localparam logic [3:0] S_CP_WAIT  = 4'd4;
  localparam logic [3:0] S_ST_ISSUE = 4'd5;
  localparam logic [3:0] S_ST_WAIT  = 4'd6;
  localparam logic [3:0] S_NEXT     = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;

  logic [3:0]     state_q, state_d;
  logic           pend_q;
  logic [AW-1:0]  tile_len_q;
  logic [XAW-1:0] remaining_q;
  logic [XAW-1:0] raddr_q, waddr_q, tile_cnt_q;
  logic [AW-1:0]  iolen_q, iolen_d;
  logic           ld_start_q, cp_start_q, st_start_q;
  logic           busy_q, done_q, err_q;

  logic           accept;
  logic [XAW-1:0] rem_next, rem_sel, step;

  assign accept   = (state_q == S_IDLE) && !pend_q && cfg_start;
  assign step     = XAW'(iolen_q) << 2;
  assign rem_next = remaining_q - XAW'(iolen_q);
  assign rem_sel  = (state_q == S_NEXT) ? rem_next : remaining_q;
  assign iolen_d  = (rem_sel < XAW'(tile_len_q)) ? rem_sel[AW-1:0] : tile_len_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          if (tile_len_q == '0 || remaining_q == '0) state_d = S_FIN;
          else                                      state_d = S_LD_ISSUE;
        end
      end
      S_LD_ISSUE: state_d = S_LD_WAIT;
      S_LD_WAIT:  if (load_data_done) state_d = S_CP_ISSUE;
      S_CP_ISSUE: state_d = S_CP_WAIT;
      S_CP_WAIT:  if (compute_done) state_d = S_ST_ISSUE;
      S_ST_ISSUE: state_d = S_ST_WAIT;
      S_ST_WAIT:  if (store_data_done) state_d = S_NEXT;
      S_NEXT:     state_d = (rem_next != '0) ? S_LD_ISSUE : S_FIN;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      tile_len_q  <= '0;
      remaining_q <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      tile_cnt_q  <= '0;
      iolen_q     <= '0;
      ld_start_q  <= 1'b0;
      cp_start_q  <= 1'b0;
      st_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_q      <= 1'b1;
        tile_len_q  <= cfg_tile_len;
        remaining_q <= cfg_total_len;
        raddr_q     <= cfg_src_base;
        waddr_q     <= cfg_dst_base;
        tile_cnt_q  <= '0;
      end else if (state_q == S_IDLE) begin
        pend_q <= 1'b0;
      end
      if (state_q == S_NEXT) begin
        remaining_q <= rem_next;
        raddr_q     <= raddr_q + step;
        waddr_q     <= waddr_q + step;
        tile_cnt_q  <= tile_cnt_q + XAW'(1);
      end
      if (state_d == S_LD_ISSUE) iolen_q <= iolen_d;
      // Strobes are registered on entry, so each is visible during its own state.
      ld_start_q <= (state_d == S_LD_ISSUE);
      cp_start_q <= (state_d == S_CP_ISSUE);
      st_start_q <= (state_d == S_ST_ISSUE);
      done_q     <= (state_d == S_FIN);
      err_q      <= (state_q == S_IDLE) && pend_q && (tile_len_q == '0);
      busy_q     <= (state_d != S_IDLE) || accept;
    end
  end

  assign param_raddr      = raddr_q;
  assign param_waddr      = waddr_q;
  assign param_iolen      = iolen_q;
  assign load_data_start  = ld_start_q;
  assign compute_start    = cp_start_q;
  assign store_data_start = st_start_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign tile_cnt         = tile_cnt_q;

endmodule

// File: tb/tb_tile_load_store_ctrl.sv
// Scoreboard bench for tile_load_store_ctrl: a job-level model queues expected tiles/jobs,
// a negedge monitor pops and compares whenever the DUT pulses load_data_start or done.
module tb_tile_load_store_ctrl;
  localparam int AW  = 12;
  localparam int XAW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_start;
  logic [XAW-1:0] cfg_src_base, cfg_dst_base, cfg_total_len;
  logic [AW-1:0]  cfg_tile_len;
  logic [XAW-1:0] param_raddr, param_waddr, tile_cnt;
  logic [AW-1:0]  param_iolen;
  logic           load_data_start, load_data_done;
  logic           compute_start, compute_done;
  logic           store_data_start, store_data_done;
  logic           busy, done, err;

  tile_load_store_ctrl #(.AW(AW), .XAW(XAW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .cfg_total_len(cfg_total_len), .cfg_tile_len(cfg_tile_len),
    .param_raddr(param_raddr), .param_waddr(param_waddr), .param_iolen(param_iolen),
    .load_data_start(load_data_start), .load_data_done(load_data_done),
    .compute_start(compute_start), .compute_done(compute_done),
    .store_data_start(store_data_start), .store_data_done(store_data_done),
    .busy(busy), .done(done), .err(err), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XAW-1:0] r;
    logic [XAW-1:0] w;
    logic [AW-1:0]  n;
    int             idx;
  } tile_t;
  typedef struct {
    bit err;
    int tiles;
  } job_t;

  tile_t exp_tiles[$];
  job_t  exp_jobs[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  longint cyc = 0, last_evt = 0;
  int     ld_seen = 0, cp_seen = 0, st_seen = 0;
  bit     wait_store = 0;
  tile_t  mt;
  job_t   mj;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (cfg_start && !busy) begin
        ld_seen = 0; cp_seen = 0; st_seen = 0;
        wait_store = 0;
        last_evt = cyc;
      end
      if (load_data_start) begin
        ld_seen++;
        chk("load_latency", 64'(cyc - last_evt), 64'd2);
        if (exp_tiles.size() == 0) chk("unexpected_load", 64'd1, 64'd0);
        else begin
          mt = exp_tiles.pop_front();
          chk("raddr", 64'(param_raddr), 64'(mt.r));
          chk("waddr", 64'(param_waddr), 64'(mt.w));
          chk("iolen", 64'(param_iolen), 64'(mt.n));
          chk("tile_cnt_at_load", 64'(tile_cnt), 64'(mt.idx));
        end
      end
      if (compute_start) cp_seen++;
      if (store_data_start) begin
        st_seen++;
        wait_store = 1;
      end
      if (store_data_done && wait_store) begin
        wait_store = 0;
        last_evt = cyc;
      end
      if (done) begin
        if (exp_jobs.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          mj = exp_jobs.pop_front();
          chk("err", 64'(err), 64'(mj.err));
          chk("busy_at_done", 64'(busy), 64'd1);
          chk("tile_cnt_at_done", 64'(tile_cnt), 64'(mj.tiles));
          chk("loads_per_job", 64'(ld_seen), 64'(mj.tiles));
          chk("computes_per_job", 64'(cp_seen), 64'(mj.tiles));
          chk("stores_per_job", 64'(st_seen), 64'(mj.tiles));
        end
      end else if (err) begin
        chk("err_without_done", 64'd1, 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_for(input int code, input string name);
    int  n = 0;
    bit  hit = 0;
    while (n < 200 && !hit) begin
      @(negedge clk);
      n++;
      case (code)
        0: hit = load_data_start;
        1: hit = compute_start;
        2: hit = store_data_start;
        default: hit = done;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: pulse not seen within 200 cycles", name);
    end
  endtask

  task automatic set_done(input int code, input logic v);
    case (code)
      0: load_data_done = v;
      1: compute_done = v;
      default: store_data_done = v;
    endcase
  endtask

  task automatic pulse_in(input int code);
    int d = $urandom_range(0, 3);
    @(posedge clk);
    repeat (d) @(posedge clk);
    #1 set_done(code, 1'b1);
    @(posedge clk);
    #1 set_done(code, 1'b0);
  endtask

  // Reference: a job is a list of tiles of min(remaining, tile) words, addresses advancing 4 bytes/word.
  task automatic model_job(input logic [XAW-1:0] src, input logic [XAW-1:0] dst,
                           input logic [XAW-1:0] total, input logic [AW-1:0] tl,
                           output int ntiles, output tile_t first);
    logic [XAW-1:0] rem = total, r = src, w = dst;
    tile_t t;
    job_t  j;
    ntiles = 0;
    first = '{r: src, w: dst, n: '0, idx: 0};
    if (tl != 0) begin
      while (rem != 0) begin
        t.r = r; t.w = w; t.idx = ntiles;
        t.n = (rem < XAW'(tl)) ? rem[AW-1:0] : tl;
        if (ntiles == 0) first = t;
        exp_tiles.push_back(t);
        r = r + XAW'(t.n) * 4;
        w = w + XAW'(t.n) * 4;
        rem = rem - XAW'(t.n);
        ntiles++;
      end
    end
    j.err = (tl == 0);
    j.tiles = ntiles;
    exp_jobs.push_back(j);
  endtask

  task automatic drive_start(input logic [XAW-1:0] src, input logic [XAW-1:0] dst,
                             input logic [XAW-1:0] total, input logic [AW-1:0] tl);
    @(posedge clk);
    #1;
    cfg_src_base = src; cfg_dst_base = dst; cfg_total_len = total; cfg_tile_len = tl;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    cfg_src_base = $urandom; cfg_dst_base = $urandom;
    cfg_total_len = $urandom; cfg_tile_len = AW'($urandom);
  endtask

  task automatic run_job(input logic [XAW-1:0] src, input logic [XAW-1:0] dst,
                         input logic [XAW-1:0] total, input logic [AW-1:0] tl, input bit inject);
    int    nt;
    tile_t first;
    model_job(src, dst, total, tl, nt, first);
    drive_start(src, dst, total, tl);
    for (int i = 0; i < nt; i++) begin
      wait_for(0, "load_start");
      if (inject && i == 0) begin
        @(posedge clk);
        #1;
        compute_done = 1'b1; store_data_done = 1'b1; cfg_start = 1'b1;
        cfg_src_base = $urandom; cfg_total_len = 0; cfg_tile_len = '0;
        @(posedge clk);
        #1;
        compute_done = 1'b0; store_data_done = 1'b0; cfg_start = 1'b0;
        chk("hold_raddr", 64'(param_raddr), 64'(first.r));
        chk("hold_waddr", 64'(param_waddr), 64'(first.w));
        chk("hold_iolen", 64'(param_iolen), 64'(first.n));
        chk("hold_busy", 64'(busy), 64'd1);
      end
      pulse_in(0);
      wait_for(1, "compute_start");
      pulse_in(1);
      wait_for(2, "store_start");
      pulse_in(2);
    end
    wait_for(3, "done");
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic reset_check(input string name);
    chk(name, 64'(|{param_raddr, param_waddr, param_iolen, load_data_start, compute_start,
                    store_data_start, busy, done, err, tile_cnt}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_src_base = '0; cfg_dst_base = '0; cfg_total_len = '0; cfg_tile_len = '0;
    load_data_done = 1'b0; compute_done = 1'b0; store_data_done = 1'b0;
    #12;
    reset_check("reset_outputs");
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_job(32'h1000, 32'h8000, 2048, 12'd1024, 1'b0);
    run_job(32'h1000, 32'h8000, 2500, 12'd1024, 1'b0);
    run_job(32'h2000, 32'h3000, 0, 12'd16, 1'b0);
    run_job(32'h2000, 32'h3000, 40, 12'd0, 1'b0);
    run_job(32'h4000, 32'h5000, 10, 12'd4, 1'b1);
    run_job(32'hFFFF_F000, 32'h0, 2048, 12'd1024, 1'b0);

    // abort in CP_WAIT, then a fresh job must start from tile 0
    begin
      int    nt;
      tile_t first;
      model_job(32'h100, 32'h200, 12, 12'd4, nt, first);
      drive_start(32'h100, 32'h200, 12, 12'd4);
      wait_for(0, "load_start_rst");
      pulse_in(0);
      wait_for(1, "compute_start_rst");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 reset_check("midjob_reset_outputs");
      exp_tiles.delete();
      exp_jobs.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
    end
    run_job(32'h700, 32'h900, 9, 12'd4, 1'b0);

    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] tl;
      tl = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 6));
      run_job($urandom, $urandom, $urandom_range(0, 20), tl, ($urandom_range(0, 3) == 0));
    end

    chk("tiles_left", 64'(exp_tiles.size()), 64'd0);
    chk("jobs_left", 64'(exp_jobs.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
